// File: rtl/alu_driver.sv
// Command/response wrapper around an external combinational 4-bit ALU: registers operands,
// waits SETTLE_CYCLES, then captures the result. Optional golden checker under `ALU_CHECK_EN`.
module alu_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    input  logic [1:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_c,
    output logic        rsp_ovf,
    output logic [1:0]  rsp_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_ctrl0,
    output logic        alu_ctrl1,
    input  logic [3:0]  alu_c,
    input  logic        alu_ovf,
    output logic        busy,
    output logic [7:0]  op_count
`ifdef ALU_CHECK_EN
    ,
    output logic        chk_err,
    output logic [7:0]  chk_err_count
`endif
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OPC_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_rsp_c;
    logic                r_rsp_ovf;
    logic [OP_W-1:0]     r_rsp_op;
    logic [OPC_W-1:0]    r_op_count;
    logic                w_cmd_ready;
    logic                w_rsp_valid;
    logic                w_busy;
    logic                w_accept;
    logic                w_capture;
    logic                w_done;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_capture = (r_state == S_SETTLE) && (r_cnt == '0);
    assign w_done    = (r_state == S_RESP) && rsp_ready;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)  w_next = S_SETTLE;
            S_SETTLE: if (w_capture) w_next = S_RESP;
            S_RESP:   if (w_done)    w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_RESP:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, settle counter, response and completion-count datapath
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_op       <= '0;
            r_rsp_c    <= '0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_op   <= '0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a <= cmd_a;
                r_alu_b <= cmd_b;
                r_op    <= cmd_op;
                r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            end
            if (r_state == S_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_rsp_c   <= alu_c;
                r_rsp_ovf <= alu_ovf;
                r_rsp_op  <= r_op;
            end
            if (w_done) begin
                r_op_count <= r_op_count + OPC_W'(1);
            end
        end
    end

`ifdef ALU_CHECK_EN
    logic [DATA_W:0]   w_golden;
    logic              r_chk_err;
    logic [OPC_W-1:0]  r_chk_cnt;

    // Reference result for the latched operands
    always_comb begin
        w_golden = '0;
        case (r_op)
            2'd0:    w_golden = {1'b0, r_alu_a} + {1'b0, r_alu_b};
            2'd1:    w_golden = {1'b0, r_alu_a} - {1'b0, r_alu_b};
            2'd2:    w_golden = {1'b0, r_alu_a & r_alu_b};
            default: w_golden = {4'b0000, r_alu_a > r_alu_b};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_chk_err <= 1'b0;
            r_chk_cnt <= '0;
        end else if (w_capture && ({alu_ovf, alu_c} != w_golden)) begin
            r_chk_err <= 1'b1;
            if (r_chk_cnt != '1) r_chk_cnt <= r_chk_cnt + OPC_W'(1);
        end
    end

    assign chk_err       = r_chk_err;
    assign chk_err_count = r_chk_cnt;
`endif

    assign cmd_ready = w_cmd_ready;
    assign rsp_valid = w_rsp_valid;
    assign busy      = w_busy;
    assign rsp_c     = r_rsp_c;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_op    = r_rsp_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_ctrl0 = r_op[0];
    assign alu_ctrl1 = r_op[1];
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: one instance with SETTLE_CYCLES=1 and one with 4,
// each wired to a behavioural 4-bit ALU. Checker tests run when ALU_CHECK_EN is defined.
module tb_alu_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {4'b0000, a > b};
        endcase
    endfunction

    // SETTLE_CYCLES = 1 instance
    logic       rst1, cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, rsp_ovf1;
    logic [3:0] cmd_a1, cmd_b1, rsp_c1, alu_a1, alu_b1, alu_c1;
    logic [1:0] cmd_op1, rsp_op1;
    logic       alu_ctrl0_1, alu_ctrl1_1, alu_ovf1, busy1, bad1;
    logic [7:0] op_count1;
    logic [4:0] m1;
`ifdef ALU_CHECK_EN
    logic       chk_err1;
    logic [7:0] chk_cnt1;
`endif
    assign m1 = alu_f(alu_a1, alu_b1, {alu_ctrl1_1, alu_ctrl0_1});
    assign {alu_ovf1, alu_c1} = (bad1 && alu_a1 == 4'd7 && alu_b1 == 4'd1) ? 5'd0 : m1;

    alu_driver #(.SETTLE_CYCLES(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst1),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_c(rsp_c1), .rsp_ovf(rsp_ovf1), .rsp_op(rsp_op1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl0(alu_ctrl0_1), .alu_ctrl1(alu_ctrl1_1),
        .alu_c(alu_c1), .alu_ovf(alu_ovf1),
        .busy(busy1), .op_count(op_count1)
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err1), .chk_err_count(chk_cnt1)
`endif
    );

    // SETTLE_CYCLES = 4 instance
    logic       rst4, cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4, rsp_ovf4;
    logic [3:0] cmd_a4, cmd_b4, rsp_c4, alu_a4, alu_b4, alu_c4;
    logic [1:0] cmd_op4, rsp_op4;
    logic       alu_ctrl0_4, alu_ctrl1_4, alu_ovf4, busy4;
    logic [7:0] op_count4;
`ifdef ALU_CHECK_EN
    logic       chk_err4;
    logic [7:0] chk_cnt4;
`endif
    assign {alu_ovf4, alu_c4} = alu_f(alu_a4, alu_b4, {alu_ctrl1_4, alu_ctrl0_4});

    alu_driver #(.SETTLE_CYCLES(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst4),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_op(cmd_op4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_c(rsp_c4), .rsp_ovf(rsp_ovf4), .rsp_op(rsp_op4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_ctrl0(alu_ctrl0_4), .alu_ctrl1(alu_ctrl1_4),
        .alu_c(alu_c4), .alu_ovf(alu_ovf4),
        .busy(busy4), .op_count(op_count4)
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err4), .chk_err_count(chk_cnt4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One complete transaction on dut1 with an immediate response handshake
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] ec, input logic eovf, input logic [7:0] ecnt);
        cmd_a1 = a; cmd_b1 = b; cmd_op1 = op; cmd_valid1 = 1'b1;
        tick();
        cmd_valid1 = 1'b0;
        chk("acc_busy", busy1, 1);
        chk("acc_cmd_ready", cmd_ready1, 0);
        chk("acc_rsp_valid", rsp_valid1, 0);
        chk("acc_alu_a", alu_a1, a);
        chk("acc_alu_b", alu_b1, b);
        chk("acc_alu_ctrl", {alu_ctrl1_1, alu_ctrl0_1}, op);
        tick();
        chk("rsp_valid", rsp_valid1, 1);
        chk("rsp_c", rsp_c1, ec);
        chk("rsp_ovf", rsp_ovf1, eovf);
        chk("rsp_op", rsp_op1, op);
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        chk("done_rsp_valid", rsp_valid1, 0);
        chk("done_cmd_ready", cmd_ready1, 1);
        chk("done_busy", busy1, 0);
        chk("done_op_count", op_count1, ecnt);
        chk("done_alu_a_held", alu_a1, a);
    endtask

    initial begin
        bad1 = 1'b0;
        rst1 = 1'b1; cmd_valid1 = 1'b0; rsp_ready1 = 1'b0; cmd_a1 = 4'd0; cmd_b1 = 4'd0; cmd_op1 = 2'd0;
        rst4 = 1'b1; cmd_valid4 = 1'b0; rsp_ready4 = 1'b0; cmd_a4 = 4'd0; cmd_b4 = 4'd0; cmd_op4 = 2'd0;
        #2;
        tick();
        tick();
        rst1 = 1'b0;
        rst4 = 1'b0;

        // Reset state
        chk("rst_cmd_ready", cmd_ready1, 1);
        chk("rst_rsp_valid", rsp_valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_op_count", op_count1, 0);
        chk("rst_alu", {alu_a1, alu_b1, alu_ctrl1_1, alu_ctrl0_1}, 0);
        chk("rst_rsp", {rsp_c1, rsp_ovf1, rsp_op1}, 0);
        chk("rst4_cmd_ready", cmd_ready4, 1);

        // Basic ops
        run_op(4'd9,  4'd8,  2'd0, 4'd1,  1'b1, 8'd1);
        run_op(4'd3,  4'd5,  2'd1, 4'd14, 1'b1, 8'd2);
        run_op(4'd5,  4'd3,  2'd3, 4'd1,  1'b0, 8'd3);
        run_op(4'd12, 4'd10, 2'd2, 4'd8,  1'b0, 8'd4);

        // Backpressure with a changing, still-valid command
        cmd_a1 = 4'd2; cmd_b1 = 4'd3; cmd_op1 = 2'd0; cmd_valid1 = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_a1 = 4'(i + 8); cmd_b1 = 4'(i + 1); cmd_op1 = 2'(i);
            tick();
            chk("stall_rsp_valid", rsp_valid1, 1);
            chk("stall_rsp", {rsp_c1, rsp_ovf1, rsp_op1}, {4'd5, 1'b0, 2'd0});
            chk("stall_cmd_ready", cmd_ready1, 0);
            chk("stall_alu_a", alu_a1, 2);
        end
        cmd_a1 = 4'd4; cmd_b1 = 4'd4; cmd_op1 = 2'd2; rsp_ready1 = 1'b1;
        tick();
        chk("b2b_idle", cmd_ready1, 1);
        chk("b2b_count", op_count1, 5);
        tick();
        cmd_valid1 = 1'b0;
        chk("b2b_accept", busy1, 1);
        chk("b2b_alu_a", alu_a1, 4);
        tick();
        chk("b2b_rsp", {rsp_valid1, rsp_c1, rsp_ovf1, rsp_op1}, {1'b1, 4'd4, 1'b0, 2'd2});
        tick();
        rsp_ready1 = 1'b0;
        chk("b2b_count2", op_count1, 6);

        // SETTLE_CYCLES=4 latency
        cmd_a4 = 4'd7; cmd_b4 = 4'd6; cmd_op4 = 2'd0; cmd_valid4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        chk("s4_busy", busy4, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("s4_early", rsp_valid4, 0);
        end
        tick();
        chk("s4_rsp", {rsp_valid4, rsp_c4, rsp_ovf4}, {1'b1, 4'd13, 1'b0});
        rsp_ready4 = 1'b1;
        tick();
        rsp_ready4 = 1'b0;
        chk("s4_count", op_count4, 1);

        // Reset during SETTLE discards the command
        cmd_a4 = 4'd1; cmd_b4 = 4'd1; cmd_op4 = 2'd0; cmd_valid4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        tick();
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("s4_rst_idle", {cmd_ready4, busy4, rsp_valid4}, 3'b100);
        chk("s4_rst_count", op_count4, 0);
        chk("s4_rst_alu_a", alu_a4, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s4_no_rsp", rsp_valid4, 0);
        end

`ifdef ALU_CHECK_EN
        // Checker flags a wrong ALU result and stays sticky
        chk("chk_clear", chk_err1, 0);
        bad1 = 1'b1;
        run_op(4'd7, 4'd1, 2'd0, 4'd0, 1'b0, 8'd7);
        bad1 = 1'b0;
        chk("chk_err_set", chk_err1, 1);
        chk("chk_cnt_1", chk_cnt1, 1);
        run_op(4'd1, 4'd1, 2'd0, 4'd2, 1'b0, 8'd8);
        chk("chk_err_sticky", chk_err1, 1);
        chk("chk_cnt_hold", chk_cnt1, 1);
`endif

        // Reset wins over a response handshake on the same edge
        cmd_a1 = 4'd6; cmd_b1 = 4'd1; cmd_op1 = 2'd0; cmd_valid1 = 1'b1;
        tick();
        cmd_valid1 = 1'b0;
        tick();
        chk("prio_in_resp", rsp_valid1, 1);
        rsp_ready1 = 1'b1;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        rsp_ready1 = 1'b0;
        chk("prio_count", op_count1, 0);
        chk("prio_idle", {cmd_ready1, rsp_valid1, busy1}, 3'b100);
`ifdef ALU_CHECK_EN
        chk("prio_chk_clr", {chk_err1, chk_cnt1}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
